// File: rtl/ccip_std_afu_if.sv
// ccip_std_afu_if: CCI-P style MMIO and memory channel bundle between shim and AFU
interface ccip_std_afu_if;
  logic [1:0]   pwr_state;
  logic         error;
  logic         mmio_req_valid;
  logic         mmio_req_write;
  logic [15:0]  mmio_req_addr;
  logic [63:0]  mmio_req_data;
  logic [8:0]   mmio_req_tid;
  logic         mmio_rsp_valid;
  logic [8:0]   mmio_rsp_tid;
  logic [63:0]  mmio_rsp_data;
  logic         rd_req_valid;
  logic [41:0]  rd_req_addr;
  logic [15:0]  rd_req_mdata;
  logic         rd_almfull;
  logic         rd_rsp_valid;
  logic [15:0]  rd_rsp_mdata;
  logic [511:0] rd_rsp_data;
  logic         wr_req_valid;
  logic [41:0]  wr_req_addr;
  logic [15:0]  wr_req_mdata;
  logic [511:0] wr_req_data;
  logic         wr_almfull;
  logic         wr_rsp_valid;
  logic [15:0]  wr_rsp_mdata;
  modport master (
    output pwr_state, error, mmio_req_valid, mmio_req_write, mmio_req_addr, mmio_req_data,
           mmio_req_tid, rd_almfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data, wr_almfull,
           wr_rsp_valid, wr_rsp_mdata,
    input  mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, rd_req_valid, rd_req_addr,
           rd_req_mdata, wr_req_valid, wr_req_addr, wr_req_mdata, wr_req_data
  );
  modport slave (
    input  pwr_state, error, mmio_req_valid, mmio_req_write, mmio_req_addr, mmio_req_data,
           mmio_req_tid, rd_almfull, rd_rsp_valid, rd_rsp_mdata, rd_rsp_data, wr_almfull,
           wr_rsp_valid, wr_rsp_mdata,
    output mmio_rsp_valid, mmio_rsp_tid, mmio_rsp_data, rd_req_valid, rd_req_addr,
           rd_req_mdata, wr_req_valid, wr_req_addr, wr_req_mdata, wr_req_data
  );
endinterface

// File: rtl/ccip_std_afu.sv
// ccip_std_afu: MMIO CSR block plus a one-line-at-a-time cache-line copy engine
module ccip_std_afu #(
  parameter logic [63:0] AFU_ID_L = 64'h0,
  parameter logic [63:0] AFU_ID_H = 64'h0
) (
  input logic CLK,
  input logic RST_N,
  ccip_std_afu_if.slave bus
);
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE} state_t;
  state_t       state_q, state_d;
  logic [41:0]  src_q, src_d, dst_q, dst_d;
  logic [31:0]  num_q, num_d, i_q, i_d, cnt_q, cnt_d;
  logic         done_q, done_d, err_q, err_d;
  logic [511:0] data_q, data_d;
  logic         rsp_valid_q;
  logic [8:0]   rsp_tid_q;
  logic [63:0]  rsp_data_q, rdata;
  logic [14:0]  idx;
  logic         wr_en, idle, busy, start, mem_ok, rd_go, wr_go, rd_hit, wr_hit;
  assign idx    = bus.mmio_req_addr[15:1];
  assign idle   = state_q == IDLE;
  assign busy   = !idle;
  assign wr_en  = bus.mmio_req_valid && bus.mmio_req_write;
  assign start  = wr_en && idx == 15'd7 && bus.mmio_req_data[0] && idle && !bus.error;
  assign mem_ok = bus.pwr_state == 2'b00;
  assign rd_go  = state_q == RD_REQ && !bus.rd_almfull && mem_ok;
  assign wr_go  = state_q == WR_REQ && !bus.wr_almfull && mem_ok;
  assign rd_hit = state_q == RD_WAIT && bus.rd_rsp_valid && bus.rd_rsp_mdata == i_q[15:0];
  assign wr_hit = state_q == WR_WAIT && bus.wr_rsp_valid && bus.wr_rsp_mdata == i_q[15:0];
  assign bus.rd_req_valid   = rd_go;
  assign bus.rd_req_addr    = src_q + {10'd0, i_q};
  assign bus.rd_req_mdata   = i_q[15:0];
  assign bus.wr_req_valid   = wr_go;
  assign bus.wr_req_addr    = dst_q + {10'd0, i_q};
  assign bus.wr_req_mdata   = i_q[15:0];
  assign bus.wr_req_data    = data_q;
  assign bus.mmio_rsp_valid = rsp_valid_q;
  assign bus.mmio_rsp_tid   = rsp_tid_q;
  assign bus.mmio_rsp_data  = rsp_data_q;
  // CSR read mux; STATUS reflects the live engine state
  always_comb begin
    rdata = '0;
    case (idx)
      15'd0:   rdata = 64'h1000_0100_0000_0000;
      15'd1:   rdata = AFU_ID_L;
      15'd2:   rdata = AFU_ID_H;
      15'd4:   rdata = {22'd0, src_q};
      15'd5:   rdata = {22'd0, dst_q};
      15'd6:   rdata = {32'd0, num_q};
      15'd8:   rdata = {cnt_q, 29'd0, err_q, done_q, busy};
      default: rdata = '0;
    endcase
  end
  // Copy FSM next state, CSR writes and counters; an error abort overrides everything
  always_comb begin
    state_d = state_q;
    src_d   = wr_en && idle && idx == 15'd4 ? bus.mmio_req_data[41:0] : src_q;
    dst_d   = wr_en && idle && idx == 15'd5 ? bus.mmio_req_data[41:0] : dst_q;
    num_d   = wr_en && idle && idx == 15'd6 ? bus.mmio_req_data[31:0] : num_q;
    i_d     = i_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    err_d   = err_q;
    data_d  = data_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = num_q == 32'd0 ? DONE : RD_REQ;
        i_d     = '0;
        cnt_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
      RD_REQ:  state_d = rd_go ? RD_WAIT : RD_REQ;
      RD_WAIT: if (rd_hit) begin
        state_d = WR_REQ;
        data_d  = bus.rd_rsp_data;
      end
      WR_REQ:  state_d = wr_go ? WR_WAIT : WR_REQ;
      WR_WAIT: if (wr_hit) begin
        state_d = i_q + 32'd1 == num_q ? DONE : RD_REQ;
        i_d     = i_q + 32'd1;
        cnt_d   = cnt_q + 32'd1;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (!idle && bus.error) begin
      state_d = IDLE;
      err_d   = 1'b1;
      done_d  = 1'b0;
    end
  end
  // State registers, async cleared so a mid-copy reset stops requests at once
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      num_q       <= '0;
      i_q         <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      num_q       <= num_d;
      i_q         <= i_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      data_q      <= data_d;
      rsp_valid_q <= bus.mmio_req_valid && !bus.mmio_req_write;
      rsp_tid_q   <= bus.mmio_req_tid;
      rsp_data_q  <= rdata;
    end
  end
endmodule

// File: tb/tb_ccip_std_afu.sv
// tb_ccip_std_afu: directed checks of CSRs, line copy, back-pressure, abort and reset
module tb_ccip_std_afu;
  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [41:0] rd_a[$];
  logic [41:0] wr_a[$];
  logic [15:0] rd_m[$];
  logic [15:0] wr_m[$];
  logic [63:0] wr_d[$];
  logic        wr_hi[$];
  logic        rd_seen = 1'b0;
  logic        wr_seen = 1'b0;
  logic        bad_tag = 1'b0;
  logic [41:0] rd_addr_l = '0;
  logic [15:0] rd_tag_l = '0;
  logic [15:0] wr_tag_l = '0;
  logic [63:0] st;
  always #5 clk = ~clk;
  ccip_std_afu_if bus();
  ccip_std_afu #(.AFU_ID_L(ID_L), .AFU_ID_H(ID_H)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
  // Record requests exactly as the DUT issues them on the active edge
  always @(posedge clk) begin
    if (rst_n && bus.rd_req_valid) begin
      rd_a.push_back(bus.rd_req_addr);
      rd_m.push_back(bus.rd_req_mdata);
      rd_addr_l = bus.rd_req_addr;
      rd_tag_l  = bus.rd_req_mdata;
      rd_seen   = 1'b1;
    end
    if (rst_n && bus.wr_req_valid) begin
      wr_a.push_back(bus.wr_req_addr);
      wr_m.push_back(bus.wr_req_mdata);
      wr_d.push_back(bus.wr_req_data[63:0]);
      wr_hi.push_back(|bus.wr_req_data[511:64]);
      wr_tag_l = bus.wr_req_mdata;
      wr_seen  = 1'b1;
    end
  end
  // Memory model: line data equals its address, responses two cycles after a request
  initial begin
    int rd_pend = 0;
    int wr_pend = 0;
    bus.rd_rsp_valid = 1'b0;
    bus.rd_rsp_mdata = '0;
    bus.rd_rsp_data  = '0;
    bus.wr_rsp_valid = 1'b0;
    bus.wr_rsp_mdata = '0;
    forever begin
      @(negedge clk);
      bus.rd_rsp_valid = 1'b0;
      bus.wr_rsp_valid = 1'b0;
      if (!rst_n) begin
        rd_pend = 0;
        wr_pend = 0;
        rd_seen = 1'b0;
        wr_seen = 1'b0;
      end else begin
        if (rd_pend > 0) begin
          rd_pend--;
          if (rd_pend == 0) begin
            bus.rd_rsp_valid = 1'b1;
            if (bad_tag) begin
              bus.rd_rsp_mdata = rd_tag_l + 16'd1;
              bus.rd_rsp_data  = 512'(~rd_addr_l);
              bad_tag = 1'b0;
              rd_pend = 2;
            end else begin
              bus.rd_rsp_mdata = rd_tag_l;
              bus.rd_rsp_data  = 512'(rd_addr_l);
            end
          end
        end
        if (wr_pend > 0) begin
          wr_pend--;
          if (wr_pend == 0) begin
            bus.wr_rsp_valid = 1'b1;
            bus.wr_rsp_mdata = wr_tag_l;
          end
        end
        if (rd_seen) begin
          rd_seen = 1'b0;
          rd_pend = 2;
        end
        if (wr_seen) begin
          wr_seen = 1'b0;
          wr_pend = 2;
        end
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic mmio_wr(input logic [15:0] off, input logic [63:0] d);
    bus.mmio_req_valid = 1'b1;
    bus.mmio_req_write = 1'b1;
    bus.mmio_req_addr  = off >> 2;
    bus.mmio_req_data  = d;
    @(negedge clk);
    bus.mmio_req_valid = 1'b0;
    bus.mmio_req_write = 1'b0;
  endtask
  task automatic mmio_rd(input logic [15:0] off, input logic [8:0] tid, output logic [63:0] d);
    bus.mmio_req_valid = 1'b1;
    bus.mmio_req_write = 1'b0;
    bus.mmio_req_addr  = off >> 2;
    bus.mmio_req_tid   = tid;
    @(negedge clk);
    bus.mmio_req_valid = 1'b0;
    chk("rsp_valid", 64'(bus.mmio_rsp_valid), 64'd1);
    chk("rsp_tid", 64'(bus.mmio_rsp_tid), 64'(tid));
    d = bus.mmio_rsp_data;
  endtask
  task automatic rd_chk(input string tag, input logic [15:0] off, input logic [63:0] exp);
    logic [63:0] d;
    mmio_rd(off, 9'h1A5, d);
    chk(tag, d, exp);
  endtask
  task automatic setup(input logic [41:0] src, input logic [41:0] dst, input logic [31:0] num);
    mmio_wr(16'h20, 64'(src));
    mmio_wr(16'h28, 64'(dst));
    mmio_wr(16'h30, 64'(num));
    rd_a.delete(); rd_m.delete(); wr_a.delete(); wr_m.delete(); wr_d.delete(); wr_hi.delete();
  endtask
  task automatic start();
    mmio_wr(16'h38, 64'd1);
  endtask
  task automatic wait_end(output logic [63:0] s);
    logic ended = 1'b0;
    s = '0;
    for (int k = 0; k < 300 && !ended; k++) begin
      mmio_rd(16'h40, 9'h0F0, s);
      ended = s[1] | s[2];
    end
    if (!ended) chk("end_timeout", 64'd0, 64'd1);
  endtask
  task automatic chk_copy(input logic [41:0] src, input logic [41:0] dst, input int num);
    chk("rd_count", 64'(rd_a.size()), 64'(num));
    chk("wr_count", 64'(wr_a.size()), 64'(num));
    for (int k = 0; k < num && k < rd_a.size() && k < wr_a.size(); k++) begin
      chk("rd_addr", 64'(rd_a[k]), 64'(src + 42'(k)));
      chk("rd_mdata", 64'(rd_m[k]), 64'(k));
      chk("wr_addr", 64'(wr_a[k]), 64'(dst + 42'(k)));
      chk("wr_mdata", 64'(wr_m[k]), 64'(k));
      chk("wr_data", wr_d[k], 64'(src + 42'(k)));
      chk("wr_data_hi", 64'(wr_hi[k]), 64'd0);
    end
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.pwr_state = 2'b00;
    bus.error = 1'b0;
    bus.mmio_req_valid = 1'b0;
    bus.mmio_req_write = 1'b0;
    bus.mmio_req_addr = '0;
    bus.mmio_req_data = '0;
    bus.mmio_req_tid = '0;
    bus.rd_almfull = 1'b0;
    bus.wr_almfull = 1'b0;
    cycles(3);
    chk("reset_rsp_valid", 64'(bus.mmio_rsp_valid), 64'd0);
    chk("reset_rd_valid", 64'(bus.rd_req_valid), 64'd0);
    chk("reset_wr_valid", 64'(bus.wr_req_valid), 64'd0);
    rst_n = 1'b1;
    cycles(1);
    mmio_rd(16'h00, 9'd5, st); chk("dfh", st, 64'h1000_0100_0000_0000);
    mmio_rd(16'h08, 9'd6, st); chk("afu_id_l", st, ID_L);
    mmio_rd(16'h10, 9'd7, st); chk("afu_id_h", st, ID_H);
    rd_chk("rsvd_18", 16'h18, 64'd0);
    rd_chk("unmapped_48", 16'h48, 64'd0);
    mmio_wr(16'h00, 64'hFFFF);
    rd_chk("dfh_ro", 16'h00, 64'h1000_0100_0000_0000);
    cycles(1);
    chk("rsp_one_cycle", 64'(bus.mmio_rsp_valid), 64'd0);
    setup(42'h100, 42'h200, 3);
    rd_chk("src_rw", 16'h20, 64'h100);
    rd_chk("num_rw", 16'h30, 64'd3);
    start();
    wait_end(st);
    chk("copy3_status", st, {32'd3, 29'd0, 3'b010});
    chk_copy(42'h100, 42'h200, 3);
    setup(42'h10, 42'h20, 2);
    bus.rd_almfull = 1'b1;
    start();
    cycles(10);
    chk("rd_almfull_hold", 64'(rd_a.size()), 64'd0);
    bus.rd_almfull = 1'b0;
    wait_end(st);
    chk("rd_almfull_status", st, {32'd2, 29'd0, 3'b010});
    chk_copy(42'h10, 42'h20, 2);
    setup(42'h30, 42'h40, 2);
    bus.wr_almfull = 1'b1;
    start();
    cycles(10);
    chk("wr_almfull_hold", 64'(wr_a.size()), 64'd0);
    chk("wr_almfull_rd", 64'(rd_a.size()), 64'd1);
    bus.wr_almfull = 1'b0;
    wait_end(st);
    chk_copy(42'h30, 42'h40, 2);
    setup(42'h50, 42'h60, 1);
    bus.pwr_state = 2'b01;
    start();
    cycles(10);
    chk("pwr_hold", 64'(rd_a.size()), 64'd0);
    bus.pwr_state = 2'b00;
    wait_end(st);
    chk_copy(42'h50, 42'h60, 1);
    setup(42'h70, 42'h80, 0);
    start();
    mmio_rd(16'h40, 9'd9, st);
    mmio_rd(16'h40, 9'd10, st);
    chk("num0_status", st, 64'h2);
    cycles(5);
    chk("num0_no_req", 64'(rd_a.size() + wr_a.size()), 64'd0);
    setup(42'h700, 42'h800, 2);
    bus.rd_almfull = 1'b1;
    start();
    cycles(2);
    mmio_wr(16'h20, 64'h999);
    mmio_wr(16'h30, 64'd7);
    start();
    rd_chk("src_busy", 16'h20, 64'h700);
    rd_chk("num_busy", 16'h30, 64'd2);
    rd_chk("status_busy", 16'h40, 64'h1);
    bus.rd_almfull = 1'b0;
    wait_end(st);
    chk("busy_status", st, {32'd2, 29'd0, 3'b010});
    chk_copy(42'h700, 42'h800, 2);
    setup(42'h300, 42'h380, 4);
    start();
    for (int k = 0; k < 100 && wr_a.size() == 0; k++) cycles(1);
    bus.rd_almfull = 1'b1;
    st = '0;
    for (int k = 0; k < 100 && st[63:32] != 32'd1; k++) mmio_rd(16'h40, 9'd11, st);
    chk("err_pre_count", 64'(st[63:32]), 64'd1);
    bus.error = 1'b1;
    cycles(1);
    bus.error = 1'b0;
    bus.rd_almfull = 1'b0;
    cycles(10);
    chk("err_no_more_rd", 64'(rd_a.size()), 64'd1);
    chk("err_no_more_wr", 64'(wr_a.size()), 64'd1);
    rd_chk("err_status", 16'h40, {32'd1, 29'd0, 3'b100});
    rd_a.delete(); rd_m.delete(); wr_a.delete(); wr_m.delete(); wr_d.delete(); wr_hi.delete();
    start();
    wait_end(st);
    chk("restart_status", st, {32'd4, 29'd0, 3'b010});
    chk_copy(42'h300, 42'h380, 4);
    setup(42'h900, 42'hA00, 1);
    bus.error = 1'b1;
    start();
    bus.error = 1'b0;
    cycles(5);
    chk("start_err_dropped", 64'(rd_a.size()), 64'd0);
    rd_chk("start_err_status", 16'h40, {32'd4, 29'd0, 3'b010});
    bad_tag = 1'b1;
    start();
    wait_end(st);
    chk("badtag_status", st, {32'd1, 29'd0, 3'b010});
    chk_copy(42'h900, 42'hA00, 1);
    setup(42'hB00, 42'hC00, 4);
    bus.wr_almfull = 1'b1;
    start();
    cycles(10);
    chk("pre_rst_wdata", bus.wr_req_data[63:0], 64'hB00);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wdata", bus.wr_req_data[63:0], 64'd0);
    chk("rst_raddr", 64'(bus.rd_req_addr), 64'd0);
    chk("rst_waddr", 64'(bus.wr_req_addr), 64'd0);
    chk("rst_wvalid", 64'(bus.wr_req_valid), 64'd0);
    @(negedge clk);
    bus.wr_almfull = 1'b0;
    rst_n = 1'b1;
    cycles(10);
    chk("rst_no_rd", 64'(rd_a.size()), 64'd1);
    chk("rst_no_wr", 64'(wr_a.size()), 64'd0);
    rd_chk("rst_status", 16'h40, 64'd0);
    rd_chk("rst_src", 16'h20, 64'd0);
    rd_chk("rst_dst", 16'h28, 64'd0);
    rd_chk("rst_num", 16'h30, 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
